tx_header_insert: RTL and testbench



---
 rtl/gemac_pkg.sv | 15 +
 rtl/hdr_byte_mux.sv | 37 +++
 rtl/tx_header_insert.sv | 141 ++++++++++++++
 tb/tb_tx_header_insert.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemac_pkg.sv
// rtl/gemac_pkg.sv - shared GEMAC TX types and constants (header layout follows TX_VLAN_TAG_EN)
package gemac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int HDR_LEN_UNTAGGED = 14;
    localparam int HDR_LEN_TAGGED   = 18;
    localparam logic [15:0] VLAN_TPID = 16'h8100;

endpackage

// File: rtl/hdr_byte_mux.sv
// rtl/hdr_byte_mux.sv - selects header byte cnt from latched fields; TX_VLAN_TAG_EN inserts an 802.1Q tag
module hdr_byte_mux
    import gemac_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [47:0]      dst_addr,
    input  logic [47:0]      src_addr,
    input  logic [15:0]      ethertype,
`ifdef TX_VLAN_TAG_EN
    input  logic [15:0]      vlan_tci,
`endif
    output logic [7:0]       hdr_byte
);

`ifdef TX_VLAN_TAG_EN
    localparam int NB = HDR_LEN_TAGGED;
    logic [NB*8-1:0] hdr_vec;
    assign hdr_vec = {dst_addr, src_addr, VLAN_TPID, vlan_tci, ethertype};
`else
    localparam int NB = HDR_LEN_UNTAGGED;
    logic [NB*8-1:0] hdr_vec;
    assign hdr_vec = {dst_addr, src_addr, ethertype};
`endif

    // Byte 0 is the most significant byte of the packed header.
    always_comb begin
        hdr_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (cnt == CNT_W'(i)) begin
                hdr_byte = hdr_vec[(NB-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/tx_header_insert.sv
// rtl/tx_header_insert.sv - prepends the Ethernet header to the TX payload stream (option: TX_VLAN_TAG_EN)
module tx_header_insert
    import gemac_pkg::*;
#(
    parameter int HDR_BASE = 14,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] ethertype,
    input  logic [15:0] vlan_tci,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

`ifdef TX_VLAN_TAG_EN
    localparam int HDR_LEN = HDR_BASE + 4;
`else
    localparam int HDR_LEN = HDR_BASE;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [47:0]      dst_q;
    logic [47:0]      src_q;
    logic [15:0]      type_q;
    logic [7:0]       hdr_byte;
    logic             load;
    logic             out_accept;

    assign load       = ~out_valid | out_ready;
    assign out_accept = out_valid & out_ready;
    // Backpressure passes straight through; there is no skid buffer.
    assign in_ready   = (state == PAYLOAD) & load;

`ifdef TX_VLAN_TAG_EN
    logic [15:0] tci_q;

    hdr_byte_mux #(.CNT_W(CNT_W)) u_mux (
        .cnt       (cnt),
        .dst_addr  (dst_q),
        .src_addr  (src_q),
        .ethertype (type_q),
        .vlan_tci  (tci_q),
        .hdr_byte  (hdr_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tci_q <= '0;
        end else if (state == IDLE && in_valid) begin
            tci_q <= vlan_tci;
        end
    end
`else
    logic unused_vlan_tci;
    assign unused_vlan_tci = ^vlan_tci;

    hdr_byte_mux #(.CNT_W(CNT_W)) u_mux (
        .cnt       (cnt),
        .dst_addr  (dst_q),
        .src_addr  (src_q),
        .ethertype (type_q),
        .hdr_byte  (hdr_byte)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            type_q     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // An accepted byte empties the output register unless reloaded below.
            if (out_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dst_q  <= dst_addr;
                        src_q  <= src_addr;
                        type_q <= ethertype;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (load) begin
                        out_data  <= hdr_byte;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        cnt       <= cnt + 1'b1;
                        if (cnt == CNT_W'(HDR_LEN - 1)) begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_valid && in_ready) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        out_last  <= in_last;
                        if (in_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_accept && out_last) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_header_insert.sv
// tb/tb_tx_header_insert.sv - scoreboard bench for tx_header_insert (honours TX_VLAN_TAG_EN)
module tb_tx_header_insert;

`ifdef TX_VLAN_TAG_EN
    localparam int HDR_LEN = 18;
`else
    localparam int HDR_LEN = 14;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] dst_addr = '0;
    logic [47:0] src_addr = '0;
    logic [15:0] ethertype = '0;
    logic [15:0] vlan_tci = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int or_mode = 0;

    logic [8:0] sb[$];
    int   seen = 0;
    bit   exp_done = 0;
    bit   hold_pend = 0;
    logic [7:0] held = '0;

    tx_header_insert dut (
        .clk        (clk),
        .reset      (reset),
        .dst_addr   (dst_addr),
        .src_addr   (src_addr),
        .ethertype  (ethertype),
        .vlan_tci   (vlan_tci),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each accepted byte.
    always @(negedge clk) begin
        if (reset) begin
            seen      = 0;
            exp_done  = 0;
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, held});
            end
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            exp_done = 0;
            if (seen < HDR_LEN - 1) chk("in_ready_hdr", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
                end else begin
                    chk("out_byte", {23'd0, out_last, out_data}, {23'd0, sb.pop_front()});
                end
                seen++;
                if (out_last) begin
                    exp_done = 1;
                    seen = 0;
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = out_data;
        end
    end

    task automatic set_cfg(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] et, input logic [15:0] tci);
        dst_addr  = d;
        src_addr  = s;
        ethertype = et;
        vlan_tci  = tci;
    endtask

    task automatic push_hdr(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] et, input logic [15:0] tci);
        for (int i = 0; i < 6; i++) sb.push_back({1'b0, d[47-8*i -: 8]});
        for (int i = 0; i < 6; i++) sb.push_back({1'b0, s[47-8*i -: 8]});
`ifdef TX_VLAN_TAG_EN
        sb.push_back(9'h081);
        sb.push_back(9'h000);
        sb.push_back({1'b0, tci[15:8]});
        sb.push_back({1'b0, tci[7:0]});
`else
        if (tci === 16'hxxxx) sb.push_back(9'h1ff);
`endif
        sb.push_back({1'b0, et[15:8]});
        sb.push_back({1'b0, et[7:0]});
    endtask

    task automatic push_pl(input logic [7:0] p[$]);
        for (int i = 0; i < p.size(); i++) sb.push_back({i == p.size() - 1, p[i]});
    endtask

    task automatic send_payload(input logic [7:0] p[$], input bit chg_dst);
        bit acc;
        int n;
        for (int i = 0; i < p.size(); i++) begin
            in_valid = 1'b1;
            in_data  = p[i];
            in_last  = (i == p.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 2000);
            if (!acc) begin
                chk("src_timeout", 32'd0, 32'd1);
                break;
            end
            if (chg_dst && i == 0) dst_addr = 48'hFFFF_FFFF_FFFF;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                         input logic [15:0] tci, input logic [7:0] p[$], input bit chg_dst);
        set_cfg(d, s, et, tci);
        push_hdr(d, s, et, tci);
        push_pl(p);
        send_payload(p, chg_dst);
    endtask

    task automatic wait_done();
        int n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, frame_done}, 32'd1);
        chk("busy_clear", {31'd0, busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [8:0] lit[$];
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Header/payload order, literal expectation
        lit = '{9'h000, 9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h00A, 9'h00B, 9'h00C,
                9'h00D, 9'h00E, 9'h00F, 9'h008, 9'h000, 9'h001, 9'h002, 9'h103};
        pl = '{8'h01, 8'h02, 8'h03};
        set_cfg(48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h0800, 16'h0000);
`ifdef TX_VLAN_TAG_EN
        push_hdr(dst_addr, src_addr, ethertype, vlan_tci);
        push_pl(pl);
`else
        foreach (lit[i]) sb.push_back(lit[i]);
`endif
        send_payload(pl, 1'b0);
        wait_done();

        // Backpressure: toggle out_ready
        or_mode = 1;
        frame(48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h0800, 16'h0000, pl, 1'b0);
        wait_done();
        or_mode = 0;

        // Single-byte payload with out_ready held low mid-header
        or_mode = 2;
        set_cfg(48'hC0FF_EE12_3456, 48'h0102_0304_0506, 16'h88B5, 16'h0000);
        push_hdr(dst_addr, src_addr, ethertype, vlan_tci);
        pl = '{8'hAA};
        push_pl(pl);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, 32'h0000_00C0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        or_mode = 0;
        send_payload(pl, 1'b0);
        wait_done();

        // Config change mid-payload, back-to-back frames
        pl = '{8'h10, 8'h20, 8'h30, 8'h40};
        frame(48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h0800, 16'h0000, pl, 1'b1);
        pl = '{8'h55, 8'h66};
        frame(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 16'h0806, 16'h0000, pl, 1'b0);
        wait_done();

        // Reset mid-header
        set_cfg(48'h1122_3344_5566, 48'h7788_99AA_BBCC, 16'h0800, 16'h0000);
        push_hdr(dst_addr, src_addr, ethertype, vlan_tci);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        n = 0;
        while (seen < 7 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_byte7", seen, 32'd7);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pl = '{8'h99, 8'h98};
        frame(48'h1122_3344_5566, 48'h7788_99AA_BBCC, 16'h0800, 16'h0000, pl, 1'b0);
        wait_done();

`ifdef TX_VLAN_TAG_EN
        // Tagged header, literal bytes 12-18
        pl = '{8'h01};
        set_cfg(48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h86DD, 16'h2005);
        lit = '{9'h000, 9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h00A, 9'h00B, 9'h00C,
                9'h00D, 9'h00E, 9'h00F, 9'h081, 9'h000, 9'h020, 9'h005, 9'h086, 9'h0DD, 9'h101};
        foreach (lit[i]) sb.push_back(lit[i]);
        send_payload(pl, 1'b0);
        wait_done();
`endif

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
